// File: rtl/bus_arbiter4_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_arbiter4_if : request/grant/completion bundle between the four        |
// | requesters, the shared resource and the round-robin arbiter. Rev 1.0      |
// +----------------------------------------------------------------------------+
interface bus_arbiter4_if;
  logic [3:0] req;
  logic       bus_done;
  logic [3:0] grant;
  logic [1:0] select;
  logic       bus_valid;
  logic [3:0] ack;
  logic [3:0] err;

  modport master (
    input  req,
    input  bus_done,
    output grant,
    output select,
    output bus_valid,
    output ack,
    output err
  );

  modport slave (
    output req,
    output bus_done,
    input  grant,
    input  select,
    input  bus_valid,
    input  ack,
    input  err
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_arbiter4 : four-way round-robin arbiter with per-transaction grant    |
// | lock and BUSY timeout for one shared 32-bit datapath resource. Rev 1.0    |
// +----------------------------------------------------------------------------+
module bus_arbiter4 #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter4_if.master bus
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;
  localparam logic [CNT_WIDTH-1:0] c_TMO_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [0:0]           r_state;
  logic [1:0]           r_ptr;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [3:0]           r_grant;
  logic [1:0]           r_select;
  logic [3:0]           r_ack;
  logic [3:0]           r_err;

  logic [3:0] w_ereq;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_timeout;

  // The requester being pulsed this cycle is still dropping REQ; keep it out.
  assign w_ereq    = bus.req & ~r_ack & ~r_err;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TMO_LAST);

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_ereq[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_ptr    <= 2'd0;
      r_cnt    <= '0;
      r_grant  <= 4'd0;
      r_select <= 2'd0;
      r_ack    <= 4'd0;
      r_err    <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_ack <= 4'd0;
          r_err <= 4'd0;
          r_cnt <= '0;
          if (w_found) begin
            r_state  <= c_BUSY;
            r_grant  <= 4'd1 << w_win;
            r_select <= w_win;
          end
        end
        c_BUSY: begin
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // Completion takes precedence over a coincident timeout.
          if (bus.bus_done) begin
            r_state <= c_IDLE;
            r_grant <= 4'd0;
            r_ack   <= r_grant;
            r_ptr   <= r_select + 2'd1;
          end else if (w_timeout) begin
            r_state <= c_IDLE;
            r_grant <= 4'd0;
            r_err   <= r_grant;
            r_ptr   <= r_select + 2'd1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_grant <= 4'd0;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.select    = r_select;
  assign bus.bus_valid = (r_state == c_BUSY);
  assign bus.ack       = r_ack;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_arbiter4 : directed and randomized bench for bus_arbiter4 against  |
// | a transaction-level reference model. Rev 1.0                              |
// +----------------------------------------------------------------------------+
module tb_bus_arbiter4;

  localparam int TMO = 16;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  bus_arbiter4_if bus ();

  bus_arbiter4 #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the resource, how long it has held it, and
  // which requester is being told the outcome this cycle.
  int         m_owner;
  int         m_ptr;
  int         m_age;
  logic [1:0] m_sel;
  logic [3:0] m_ack;
  logic [3:0] m_err;

  task automatic model_step(input logic [3:0] req, input logic done, input logic rs);
    logic [3:0] elig;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_age = 0; m_sel = 2'd0; m_ack = 4'd0; m_err = 4'd0;
    end else if (m_owner < 0) begin
      elig  = req & ~m_ack & ~m_err;
      m_ack = 4'd0;
      m_err = 4'd0;
      for (int off = 0; off < 4; off++) begin
        if (m_owner < 0 && elig[(m_ptr + off) % 4]) begin
          m_owner = (m_ptr + off) % 4;
          m_sel   = 2'(m_owner);
          m_age   = 1;
        end
      end
    end else if (done) begin
      m_ack   = 4'd1 << m_owner;
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (TMO != 0 && m_age == TMO) begin
      m_err   = 4'd1 << m_owner;
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else begin
      m_age = m_age + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] r;
    logic       d;
    logic       rs;
    r  = bus.req;
    d  = bus.bus_done;
    rs = reset;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    chk("grant",     32'(bus.grant),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    chk("select",    32'(bus.select),    32'(m_sel));
    chk("bus_valid", 32'(bus.bus_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    chk("ack",       32'(bus.ack),       32'(m_ack));
    chk("err",       32'(bus.err),       32'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = 4'd0; bus.bus_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int         busy_cnt;
    int         done_pct;
    logic [3:0] pend;

    tests_run = 0; tests_failed = 0;
    reset = 1'b1; bus.req = 4'd0; bus.bus_done = 1'b0;
    m_owner = -1; m_ptr = 0; m_age = 0; m_sel = 2'd0; m_ack = 4'd0; m_err = 4'd0;

    // Reset state.
    do_reset();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_valid", 32'(bus.bus_valid), 32'd0);
    chk("rst_sel",   32'(bus.select), 32'd0);

    // Single request from requester 2, completion after three BUSY cycles.
    bus.req = 4'b0100;
    tick();
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_sel",   32'(bus.select), 32'd2);
    tick(); tick();
    bus.bus_done = 1'b1;
    tick();
    chk("single_ack",   32'(bus.ack), 32'h4);
    chk("single_idle",  32'(bus.bus_valid), 32'd0);
    bus.bus_done = 1'b0; bus.req = 4'd0;
    tick();
    chk("single_ack_once", 32'(bus.ack), 32'd0);

    // Fairness: all four requesting, completion on every first BUSY cycle.
    do_reset();
    bus.req = 4'b1111; bus.bus_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_sel",   32'(bus.select), 32'(k % 4));
      chk("rr_grant", 32'(bus.grant),  32'd1 << (k % 4));
      tick();
    end
    bus.req = 4'd0;
    tick(); tick();
    bus.bus_done = 1'b0;

    // Timeout on requester 1; BUSY must last exactly TMO cycles.
    do_reset();
    bus.req = 4'b0010;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.bus_valid) busy_cnt++;
      if (bus.err != 4'd0) break;
    end
    chk("tmo_len", 32'(busy_cnt), 32'(TMO));
    chk("tmo_err", 32'(bus.err), 32'h2);
    chk("tmo_ack", 32'(bus.ack), 32'd0);
    bus.req = 4'b0101;
    tick();
    chk("tmo_next_scan", 32'(bus.grant), 32'h4);
    bus.req = 4'd0; bus.bus_done = 1'b1;
    tick(); tick();
    bus.bus_done = 1'b0;

    // Owner drops REQ mid-transaction; grant stays locked.
    do_reset();
    bus.req = 4'b1001;
    tick();
    bus.req = 4'b1000;
    tick(); tick(); tick();
    chk("drop_hold", 32'(bus.grant), 32'h1);
    bus.bus_done = 1'b1;
    tick();
    chk("drop_ack", 32'(bus.ack), 32'h1);
    bus.bus_done = 1'b0;
    tick();
    chk("drop_next", 32'(bus.grant), 32'h8);
    bus.req = 4'd0; bus.bus_done = 1'b1;
    tick(); tick();
    bus.bus_done = 1'b0;

    // Completion on the last cycle before timeout wins over the timeout.
    do_reset();
    bus.req = 4'b0001;
    tick();
    for (int k = 0; k < TMO - 1; k++) tick();
    bus.bus_done = 1'b1;
    tick();
    chk("edge_ack", 32'(bus.ack), 32'h1);
    chk("edge_err", 32'(bus.err), 32'd0);
    bus.bus_done = 1'b0; bus.req = 4'd0;
    tick();

    // Reset during BUSY with requester 2 granted.
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.bus_done = 1'b1;
    tick();
    bus.bus_done = 1'b0; bus.req = 4'b0110;
    tick();
    chk("mid_rst_pre", 32'(bus.grant), 32'h4);
    reset = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_ack",   32'(bus.ack | bus.err), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_regrant", 32'(bus.grant), 32'h2);
    bus.req = 4'd0; bus.bus_done = 1'b1;
    tick(); tick();
    bus.bus_done = 1'b0;

    // Randomized traffic: requests held until answered, varying done rate.
    pend = 4'd0;
    for (int seg = 0; seg < 6; seg++) begin
      case (seg % 3)
        0:       done_pct = 40;
        1:       done_pct = 0;
        default: done_pct = 6;
      endcase
      for (int c = 0; c < 120; c++) begin
        pend = pend & ~(m_ack | m_err);
        if ($urandom_range(0, 2) == 0) pend[$urandom_range(0, 3)] = 1'b1;
        if (m_owner >= 0 && $urandom_range(0, 19) == 0) pend[m_owner] = 1'b0;
        bus.req      = pend;
        bus.bus_done = ($urandom_range(0, 99) < done_pct);
        reset        = ($urandom_range(0, 199) == 0);
        if (reset) pend = 4'd0;
        tick();
      end
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
